// File: rtl/priority_eval_n_if.sv
// Pixel-in, PRAM read port and blender-out signals of priority_eval_n.
// The slave modport is the resolver's view; master is the environment's view.
interface priority_eval_n_if #(
  parameter int unsigned NUM_LAYERS = 5,
  parameter int unsigned LAYER_W    = 20,
  parameter int unsigned COLOR_W    = 15,
  parameter int unsigned ID_W       = $clog2(NUM_LAYERS + 1)
);
  logic                          pix_valid;
  logic                          pix_ready;
  logic [NUM_LAYERS*LAYER_W-1:0] layers;
  logic [NUM_LAYERS-1:0]         layer_en;
  logic [4:0]                    effects_in;
  logic                          pram_req;
  logic [31:0]                   pram_addr;
  logic                          pram_gnt;
  logic                          pram_rvalid;
  logic [31:0]                   pram_rdata;
  logic                          out_valid;
  logic                          out_ready;
  logic [COLOR_W-1:0]            color0;
  logic [COLOR_W-1:0]            color1;
  logic [ID_W-1:0]               layer0;
  logic [ID_W-1:0]               layer1;
  logic [4:0]                    effects;

  modport master (
    output pix_valid, layers, layer_en, effects_in, pram_gnt, pram_rvalid, pram_rdata, out_ready,
    input  pix_ready, pram_req, pram_addr, out_valid, color0, color1, layer0, layer1, effects
  );

  modport slave (
    input  pix_valid, layers, layer_en, effects_in, pram_gnt, pram_rvalid, pram_rdata, out_ready,
    output pix_ready, pram_req, pram_addr, out_valid, color0, color1, layer0, layer1, effects
  );
endinterface

// File: rtl/priority_eval_n.sv
// Per-pixel layer priority resolver: picks the top two visible layers, fetches both
// palette colours from PRAM (one read when they share a word) and hands them to the blender.
module priority_eval_n #(
  parameter int unsigned NUM_LAYERS = 5,
  parameter int unsigned LAYER_W    = 20,
  parameter int unsigned COLOR_W    = 15,
  parameter logic [31:0] PRAM_BASE  = 32'h0500_0000,
  parameter int unsigned ID_W       = $clog2(NUM_LAYERS + 1)
) (
  input logic              clk,
  input logic              clear_n,
  priority_eval_n_if.slave bus
);
  localparam int unsigned     KEY_W    = 2 + ID_W;
  localparam logic [ID_W-1:0] BACKDROP = ID_W'(NUM_LAYERS);

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StOut} state_e;
  state_e state_q, state_d;

  logic [ID_W-1:0]    top_id, sec_id, order;
  logic [7:0]         top_idx, sec_idx;
  logic               top_bank, sec_bank;
  logic               found0, found1;
  logic [KEY_W-1:0]   key, key0, key1;
  logic [LAYER_W-1:0] desc;

  // Running top-two selection; keys are unique because order is unique per layer.
  always_comb begin
    top_id   = BACKDROP;
    sec_id   = BACKDROP;
    top_idx  = 8'd0;
    sec_idx  = 8'd0;
    top_bank = 1'b0;
    sec_bank = 1'b0;
    found0   = 1'b0;
    found1   = 1'b0;
    key      = '0;
    key0     = '0;
    key1     = '0;
    desc     = '0;
    order    = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      desc  = bus.layers[i*LAYER_W +: LAYER_W];
      order = (i == int'(NUM_LAYERS) - 1) ? '0 : ID_W'(i + 1);
      key   = {desc[10:9], order};
      if (bus.layer_en[i] && (desc[7:0] != 8'd0)) begin
        if (!found0 || (key < key0)) begin
          found1   = found0;
          key1     = key0;
          sec_id   = top_id;
          sec_idx  = top_idx;
          sec_bank = top_bank;
          found0   = 1'b1;
          key0     = key;
          top_id   = ID_W'(i);
          top_idx  = desc[7:0];
          top_bank = desc[8];
        end else if (!found1 || (key < key1)) begin
          found1   = 1'b1;
          key1     = key;
          sec_id   = ID_W'(i);
          sec_idx  = desc[7:0];
          sec_bank = desc[8];
        end
      end
    end
  end

  logic [31:0] top_addr, sec_addr;
  assign top_addr = PRAM_BASE + 32'({top_bank, top_idx, 1'b0});
  assign sec_addr = PRAM_BASE + 32'({sec_bank, sec_idx, 1'b0});

  logic [31:0]        addr0_q, addr1_q;
  logic [ID_W-1:0]    id0_q, id1_q;
  logic [4:0]         eff_q;
  logic [COLOR_W-1:0] color0_q, color1_q;
  logic [15:0]        half0, half1;
  logic               same_word, accept;

  assign same_word = addr0_q[31:2] == addr1_q[31:2];
  assign half0     = addr0_q[1] ? bus.pram_rdata[31:16] : bus.pram_rdata[15:0];
  assign half1     = addr1_q[1] ? bus.pram_rdata[31:16] : bus.pram_rdata[15:0];
  assign accept    = (state_q == StIdle) && bus.pix_valid;

  logic unused_bits;
  assign unused_bits = ^{desc, half0, half1, addr0_q[0], addr1_q[0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.pix_valid)   state_d = StReq1;
      StReq1:  if (bus.pram_gnt)    state_d = StWait1;
      StWait1: if (bus.pram_rvalid) state_d = same_word ? StOut : StReq2;
      StReq2:  if (bus.pram_gnt)    state_d = StWait2;
      StWait2: if (bus.pram_rvalid) state_d = StOut;
      StOut:   if (bus.out_ready)   state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= StIdle;
      addr0_q  <= '0;
      addr1_q  <= '0;
      id0_q    <= '0;
      id1_q    <= '0;
      eff_q    <= '0;
      color0_q <= '0;
      color1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr0_q <= top_addr;
        addr1_q <= sec_addr;
        id0_q   <= top_id;
        id1_q   <= sec_id;
        eff_q   <= bus.effects_in;
      end
      if ((state_q == StWait1) && bus.pram_rvalid) begin
        color0_q <= half0[COLOR_W-1:0];
        if (same_word) color1_q <= half1[COLOR_W-1:0];
      end
      if ((state_q == StWait2) && bus.pram_rvalid) color1_q <= half1[COLOR_W-1:0];
    end
  end

  always_comb begin
    bus.pram_addr = '0;
    if (state_q == StReq1)      bus.pram_addr = {addr0_q[31:2], 2'b00};
    else if (state_q == StReq2) bus.pram_addr = {addr1_q[31:2], 2'b00};
  end

  assign bus.pix_ready = state_q == StIdle;
  assign bus.pram_req  = (state_q == StReq1) || (state_q == StReq2);
  assign bus.out_valid = state_q == StOut;
  assign bus.color0    = color0_q;
  assign bus.color1    = color1_q;
  assign bus.layer0    = id0_q;
  assign bus.layer1    = id1_q;
  assign bus.effects   = eff_q;
endmodule

// File: tb/tb_priority_eval_n.sv
// Directed bench for priority_eval_n: table of pixels with hand-computed results,
// a PRAM responder with optional grant stalls, a mid-read reset and a 3-layer build.
module tb_priority_eval_n;
  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  priority_eval_n_if #(.NUM_LAYERS(5)) bus ();
  priority_eval_n_if #(.NUM_LAYERS(3)) bus3 ();

  priority_eval_n #(.NUM_LAYERS(5)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));
  priority_eval_n #(.NUM_LAYERS(3)) dut3 (.clk(clk), .clear_n(clear_n), .bus(bus3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] desc(input logic [7:0] idx, input logic bank,
                                       input logic [1:0] prio);
    return {9'b0, prio, bank, idx};
  endfunction

  typedef struct {
    logic [99:0] layers;
    logic [4:0]  en;
    logic [4:0]  eff;
    logic [31:0] rd0, rd1;
    int          gnt_hold, rdy_hold;
    logic [2:0]  l0, l1;
    logic [31:0] a0, a1;
    logic [14:0] c0, c1;
    int          nreq, lat;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [99:0] layers, input logic [4:0] en,
                              input logic [4:0] eff, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int gh, input int rh, input logic [2:0] l0, input logic [2:0] l1,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [14:0] c0,
                              input logic [14:0] c1, input int nreq, input int lat);
    vec_t v;
    v.layers = layers; v.en = en; v.eff = eff; v.rd0 = rd0; v.rd1 = rd1;
    v.gnt_hold = gh; v.rdy_hold = rh; v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1;
    v.c0 = c0; v.c1 = c1; v.nreq = nreq; v.lat = lat;
    return v;
  endfunction

  task automatic run_px(input vec_t v);
    int n, nreq, lat, hold, rdy;
    logic pend, done, in_req;
    logic [31:0] pdata;
    @(negedge clk);
    chk("idle_ready", 32'(bus.pix_ready), 32'd1);
    bus.layers = v.layers; bus.layer_en = v.en; bus.effects_in = v.eff;
    bus.pix_valid = 1'b1; bus.out_ready = 1'b0;
    bus.pram_rvalid = 1'b1; bus.pram_rdata = 32'hFFFF_FFFF;  // stray response while idle
    @(negedge clk);
    bus.pix_valid = 1'b0; bus.pram_rvalid = 1'b0;
    bus.layers = '1; bus.layer_en = '1; bus.effects_in = ~v.eff;
    n = 1; nreq = 0; lat = 0; hold = v.gnt_hold; rdy = 0;
    pend = 1'b0; done = 1'b0; in_req = 1'b0; pdata = '0;
    while (!done && n < 40) begin
      bus.pram_rvalid = pend;
      bus.pram_rdata  = pend ? pdata : 32'hDEAD_BEEF;
      pend = 1'b0;
      bus.pram_gnt = 1'b0;
      if (bus.pram_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          nreq++;
        end
        chk(nreq == 1 ? "addr_first" : "addr_second", bus.pram_addr, nreq == 1 ? v.a0 : v.a1);
        if (nreq == 1 && hold > 0) begin
          hold--;
        end else begin
          bus.pram_gnt = 1'b1;
          pend = 1'b1;
          pdata = (nreq == 1) ? v.rd0 : v.rd1;
          in_req = 1'b0;
        end
      end
      if (bus.out_valid) begin
        if (lat == 0) lat = n;
        chk("layer0", 32'(bus.layer0), 32'(v.l0));
        chk("layer1", 32'(bus.layer1), 32'(v.l1));
        chk("color0", 32'(bus.color0), 32'(v.c0));
        chk("color1", 32'(bus.color1), 32'(v.c1));
        chk("effects", 32'(bus.effects), 32'(v.eff));
        if (rdy < v.rdy_hold) begin
          chk("busy_not_ready", 32'(bus.pix_ready), 32'd0);
          rdy++;
        end else begin
          bus.out_ready = 1'b1;
          done = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0; bus.pram_gnt = 1'b0; bus.pram_rvalid = 1'b0;
    chk("completed", 32'(done), 32'd1);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("num_reads", 32'(nreq), 32'(v.nreq));
    chk("drop_valid", 32'(bus.out_valid), 32'd0);
    chk("back_ready", 32'(bus.pix_ready), 32'd1);
  endtask

  task automatic run3(input logic [59:0] layers, input logic [2:0] en,
                      input logic [1:0] l0, input logic [1:0] l1);
    logic pend, done;
    @(negedge clk);
    bus3.layers = layers; bus3.layer_en = en; bus3.pix_valid = 1'b1;
    @(negedge clk);
    bus3.pix_valid = 1'b0;
    pend = 1'b0; done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      bus3.pram_rvalid = pend;
      pend = bus3.pram_req;
      bus3.pram_gnt = bus3.pram_req;
      if (bus3.out_valid) begin
        chk("n3_layer0", 32'(bus3.layer0), 32'(l0));
        chk("n3_layer1", 32'(bus3.layer1), 32'(l1));
        bus3.out_ready = 1'b1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus3.out_ready = 1'b0; bus3.pram_gnt = 1'b0; bus3.pram_rvalid = 1'b0;
    chk("n3_completed", 32'(done), 32'd1);
  endtask

  initial begin
    clear_n = 1'b0;
    bus.pix_valid = 1'b0; bus.layers = '0; bus.layer_en = '0; bus.effects_in = '0;
    bus.pram_gnt = 1'b0; bus.pram_rvalid = 1'b0; bus.pram_rdata = '0; bus.out_ready = 1'b0;
    bus3.pix_valid = 1'b0; bus3.layers = '0; bus3.layer_en = '0; bus3.effects_in = '0;
    bus3.pram_gnt = 1'b0; bus3.pram_rvalid = 1'b0; bus3.pram_rdata = '0; bus3.out_ready = 1'b0;
    #2;
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
    chk("rst_pram_req", 32'(bus.pram_req), 32'd0);
    chk("rst_pram_addr", bus.pram_addr, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_color0", 32'(bus.color0), 32'd0);
    chk("rst_layer0", 32'(bus.layer0), 32'd0);
    chk("rst_effects", 32'(bus.effects), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;

    vecs[0] = mk({desc(8'h05, 1, 1), 60'b0, desc(8'h12, 0, 1)}, 5'b10001, 5'h15,
                 32'h7C1F_1234, 32'hFFFF_8421, 0, 0, 3'd4, 3'd0,
                 32'h0500_0208, 32'h0500_0024, 15'h7C1F, 15'h0421, 2, 5);
    vecs[1] = mk({40'b0, desc(8'h05, 0, 0), desc(8'h04, 0, 0), 20'b0}, 5'b00110, 5'h0A,
                 32'h1111_2222, 32'h0, 0, 0, 3'd1, 3'd2,
                 32'h0500_0008, 32'h0500_0008, 15'h2222, 15'h1111, 1, 3);
    vecs[2] = mk({20'b0, desc(8'h40, 1, 0), 60'b0}, 5'b10111, 5'h1F,
                 32'hABCD_9876, 32'h0, 0, 0, 3'd5, 3'd5,
                 32'h0500_0000, 32'h0500_0000, 15'h1876, 15'h1876, 1, 3);
    vecs[3] = mk({desc(8'h30, 0, 0), desc(8'h10, 0, 2), 20'b0, desc(8'h20, 0, 2), 20'b0},
                 5'b01010, 5'h01, 32'h0000_0123, 32'h0000_0456, 0, 0, 3'd1, 3'd3,
                 32'h0500_0040, 32'h0500_0020, 15'h0123, 15'h0456, 2, 5);
    vecs[4] = mk({desc(8'h02, 0, 2), 20'b0, desc(8'h81, 1, 0), 20'b0, desc(8'h01, 0, 3)},
                 5'b11111, 5'h04, 32'h5555_0000, 32'h0000_7FFF, 0, 0, 3'd2, 3'd4,
                 32'h0500_0300, 32'h0500_0004, 15'h5555, 15'h7FFF, 2, 5);
    vecs[5] = mk({60'b0, desc(8'hFF, 1, 3), 20'b0}, 5'b11111, 5'h10,
                 32'h2468_0000, 32'h0000_1357, 0, 0, 3'd1, 3'd5,
                 32'h0500_03FC, 32'h0500_0000, 15'h2468, 15'h1357, 2, 5);
    vecs[6] = vecs[0];
    vecs[6].gnt_hold = 4; vecs[6].rdy_hold = 3; vecs[6].lat = 9;

    for (int i = 0; i < 7; i++) run_px(vecs[i]);

    // Reset while waiting for the second colour; the late response must be dropped.
    @(negedge clk);
    bus.layers = vecs[0].layers; bus.layer_en = vecs[0].en; bus.effects_in = vecs[0].eff;
    bus.pix_valid = 1'b1;
    @(negedge clk); bus.pix_valid = 1'b0; bus.pram_gnt = 1'b1;
    @(negedge clk); bus.pram_gnt = 1'b0; bus.pram_rvalid = 1'b1; bus.pram_rdata = vecs[0].rd0;
    @(negedge clk); bus.pram_rvalid = 1'b0; bus.pram_gnt = 1'b1;
    @(negedge clk); bus.pram_gnt = 1'b0;
    chk("wait2_busy", 32'(bus.pix_ready), 32'd0);
    clear_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.pram_req), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.pix_ready), 32'd1);
    chk("mid_rst_color0", 32'(bus.color0), 32'd0);
    chk("mid_rst_layer0", 32'(bus.layer0), 32'd0);
    @(negedge clk);
    clear_n = 1'b1; bus.pram_rvalid = 1'b1; bus.pram_rdata = vecs[0].rd1;
    @(negedge clk);
    bus.pram_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.pix_ready), 32'd1);
      chk("post_rst_color1", 32'(bus.color1), 32'd0);
      @(negedge clk);
    end
    run_px(vecs[1]);

    run3({desc(8'h07, 0, 1), desc(8'h03, 0, 1), desc(8'h01, 0, 2)}, 3'b111, 2'd2, 2'd1);
    run3({desc(8'h07, 0, 1), desc(8'h03, 0, 1), desc(8'h01, 0, 2)}, 3'b000, 2'd3, 2'd3);
    run3({40'b0, desc(8'h09, 0, 0)}, 3'b111, 2'd0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
